// File: rtl/bram_read_sequencer_pkg.sv
// Shared definitions for the BRAM read sequencer.
//   clog2        - ceiling log2 used to size address, count and pointer fields
//   rd_seq_state - controller state encoding
//   fifo_depth   - skid FIFO depth for a given RAM read latency
package bram_read_sequencer_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } rd_seq_state_t;

    localparam int unsigned C_RD_LATENCY_DEFAULT = 3;

    // Enough slots for every read in flight plus two words parked at the output.
    localparam int unsigned C_FIFO_DEPTH = C_RD_LATENCY_DEFAULT + 2;

    function automatic int unsigned fifo_depth(input int unsigned rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/rd_seq_skid_fifo.sv
// Synchronous FIFO with register-held head word and an occupancy count.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (clears storage too)
//   push        - write push_data (caller guarantees no overflow)
//   push_data   - word to store
//   pop         - consume the head word (ignored when empty)
//   head_data   - current head word, stable until popped
//   head_valid  - FIFO not empty
//   count       - number of stored words
module rd_seq_skid_fifo
    import bram_read_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_read_sequencer.sv
// Read-side controller for a simple dual-port BRAM. Takes a (start address,
// word count) command, drives the RAM read port and returns the words as a
// valid/ready stream, absorbing the fixed RAM latency with a credit-limited
// skid FIFO.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake (ready only in IDLE)
//   cmd_addr, cmd_count          - start address, words to read (0..depth)
//   rdAddr, rden, rd_mode        - RAM read port (rd_mode tied to 1)
//   ram_dout                     - RAM read data
//   m_valid/m_ready/m_data/m_last- output stream, m_last on final word
//   busy                         - state is not IDLE
//   done                         - one-cycle completion pulse
// Optional: define RD_SEQ_STALL_CNT_EN to add stall_cnt, a saturating count of
// cycles with m_valid && !m_ready, cleared on command accept.
module bram_read_sequencer
    import bram_read_sequencer_pkg::*;
#(
    parameter int unsigned C_RAM_RD_WIDTH = 32,
    parameter int unsigned C_RAM_RD_DEPTH = 512,
    parameter int unsigned C_RD_LATENCY   = C_RD_LATENCY_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [clog2(C_RAM_RD_DEPTH)-1:0]  cmd_addr,
    input  logic [clog2(C_RAM_RD_DEPTH):0]    cmd_count,
    output logic [clog2(C_RAM_RD_DEPTH)-1:0]  rdAddr,
    output logic                              rden,
    output logic                              rd_mode,
    input  logic [C_RAM_RD_WIDTH-1:0]         ram_dout,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [C_RAM_RD_WIDTH-1:0]         m_data,
    output logic                              m_last,
    output logic                              busy,
    output logic                              done
`ifdef RD_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int unsigned AW         = clog2(C_RAM_RD_DEPTH);
    localparam int unsigned CW         = AW + 1;
    localparam int unsigned FIFO_DEPTH = fifo_depth(C_RD_LATENCY);
    localparam int unsigned FCW        = clog2(FIFO_DEPTH + 1);

    rd_seq_state_t             state;
    logic [CW-1:0]             remaining;
    logic [C_RD_LATENCY-1:0]   tag_vld;
    logic [C_RD_LATENCY-1:0]   tag_last;
    logic [FCW-1:0]            fifo_count;
    logic [31:0]               inflight;
    logic [31:0]               occupancy;
    logic                      issue;
    logic                      pop;
    logic [C_RAM_RD_WIDTH:0]   head_data;

    assign rd_mode = 1'b1;

    // Credit check: every word already in the FIFO or still in the RAM
    // pipeline owns a slot, so the FIFO can never overflow. Same-cycle pops
    // are deliberately not credited to keep this path short.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(C_RD_LATENCY); i++) begin
            inflight = inflight + 32'(tag_vld[i]);
        end
        occupancy = 32'(fifo_count) + inflight;
        issue     = (state == READ) && (occupancy < FIFO_DEPTH);
    end

    assign pop    = m_valid && m_ready;
    assign m_data = head_data[C_RAM_RD_WIDTH-1:0];
    assign m_last = m_valid && head_data[C_RAM_RD_WIDTH];
    assign done   = (state == FINISH) || (pop && m_last);

    // Tag pipeline mirrors the RAM latency; only tagged ram_dout is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= issue;
            tag_last[0] <= issue && (remaining == CW'(1));
            for (int i = 1; i < int'(C_RD_LATENCY); i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            rdAddr    <= '0;
            rden      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rdAddr    <= cmd_addr;
                        remaining <= cmd_count;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_count != '0) begin
                            state <= READ;
                            rden  <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        rdAddr    <= rdAddr + AW'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state     <= IDLE;
                        rden      <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_seq_skid_fifo #(
        .WIDTH (C_RAM_RD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tag_vld[C_RD_LATENCY-1]),
        .push_data  ({tag_last[C_RD_LATENCY-1], ram_dout}),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (m_valid),
        .count      (fifo_count)
    );

`ifdef RD_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cmd_valid && cmd_ready) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_read_sequencer.sv
module tb_bram_read_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 512;
    localparam int L     = 3;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_count;
    logic [AW-1:0] rdAddr;
    logic          rden;
    logic          rd_mode;
    logic [W-1:0]  ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic          done;
`ifdef RD_SEQ_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    bram_read_sequencer #(
        .C_RAM_RD_WIDTH (W),
        .C_RAM_RD_DEPTH (DEPTH),
        .C_RD_LATENCY   (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_count (cmd_count),
        .rdAddr    (rdAddr),
        .rden      (rden),
        .rd_mode   (rd_mode),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
`ifdef RD_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: read data appears L enabled cycles after the address.
    logic [W-1:0] mem  [DEPTH];
    logic [W-1:0] pipe [L];
    always @(posedge clk) begin
        if (rden) begin
            pipe[0] <= mem[rdAddr];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ram_dout = pipe[L-1];

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   zero_done = 0;
    int   zero_sent = 0;
    int   ready_mode = 1;
    int   model_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer: 0 = stalled, 1 = always ready, otherwise random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 99) < 65);
        endcase
    end

    // Monitor: pops the scoreboard on every accepted beat.
    exp_t         e;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            model_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h with empty scoreboard", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e.data));
                    check("beat_last", 64'(m_last), 64'(e.last));
                    check("beat_done", 64'(done), 64'(e.last));
                    pops++;
                end
            end else if (done) begin
                zero_done++;
            end
`ifdef RD_SEQ_STALL_CNT_EN
            if (done) check("stall_cnt", 64'(stall_cnt), 64'(model_stall));
            if (m_valid && !m_ready) model_stall++;
`endif
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic send_cmd(input int addr, input int cnt);
        int   waited;
        exp_t x;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            x.data = mem[(addr + k) % DEPTH];
            x.last = (k == cnt - 1);
            exp_q.push_back(x);
        end
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_count = (AW+1)'(cnt);
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        model_stall = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd_ready && exp_q.size() == 0) && n < 5000);
        check("drain_complete", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic zero_cmd(input int addr);
        send_cmd(addr, 0);
        @(negedge clk);
        check("zero_done_t1", 64'(done), 64'd1);
        check("zero_rden", 64'(rden), 64'd0);
        check("zero_mvalid", 64'(m_valid), 64'd0);
        check("zero_ready_t1", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("zero_ready_t2", 64'(cmd_ready), 64'd1);
        check("zero_done_t2", 64'(done), 64'd0);
        zero_sent++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rden"}, 64'(rden), 64'd0);
        check({tag, "_rdaddr"}, 64'(rdAddr), 64'd0);
        check({tag, "_rd_mode"}, 64'(rd_mode), 64'd1);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    endtask

    initial begin
        int first_k;
        int done_k;
        int p0;
        int n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_count = '0;
        m_ready   = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = i;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic read with latency and throughput timing.
        ready_mode = 1;
        send_cmd(16, 8);
        first_k = 0;
        done_k  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_rdaddr", 64'(rdAddr), 64'd16);
                check("first_rden", 64'(rden), 64'd1);
                check("busy_running", 64'(busy), 64'd1);
            end
            if (m_valid && first_k == 0) first_k = k;
            if (done && done_k == 0) done_k = k;
        end
        check("first_valid_cycle", 64'(first_k), 64'(2 + L));
        check("done_cycle", 64'(done_k), 64'(8 + L + 1));
        wait_idle();

        // Address wrap.
        send_cmd(510, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("wrap_rdaddr", 64'(rdAddr), 64'((510 + k - 1) % DEPTH));
        end
        wait_idle();

        zero_cmd(77);

        // Backpressure: issue must stop once FIFO plus in-flight reaches L+2.
        ready_mode = 0;
        send_cmd(100, 20);
        repeat (15) @(negedge clk);
        check("bp_issue_limit", 64'(rdAddr), 64'(100 + L + 2));
        check("bp_m_valid", 64'(m_valid), 64'd1);
        check("bp_head", 64'(m_data), 64'(mem[100]));
        ready_mode = 1;
        wait_idle();

        // Reset in the middle of a transfer.
        randomize_mem();
        p0 = pops;
        send_cmd(0, 8);
        n = 0;
        while ((pops - p0) < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_cmd(0, 2);
        wait_idle();

        // Full-depth command under random backpressure.
        ready_mode = 2;
        send_cmd(7, DEPTH);
        wait_idle();

        // Randomized commands.
        for (int it = 0; it < 30; it++) begin
            if ((it % 5) == 0) randomize_mem();
            if ($urandom_range(0, 7) == 0) begin
                zero_cmd($urandom_range(0, DEPTH - 1));
            end else begin
                send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 40));
                wait_idle();
            end
        end

        repeat (5) @(negedge clk);
        check("zero_done_count", 64'(zero_done), 64'(zero_sent));
        check("final_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d errors", errors);
        $fatal(1, "watchdog");
    end

endmodule
